// File: rtl/smvm_pkg.sv
// rtl/smvm_pkg.sv - shared types, default widths and saturating add for the SMVM stream engine
package smvm_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_IDX_W       = 8;
    localparam int DEF_VEC_DEPTH   = 128;
    localparam int DEF_ACC_W       = 24;
    localparam int DEF_OFIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VEC_IN,
        ST_MAT_IN,
        ST_DRAIN
    } state_e;

    // Adds two sign-extended operands and clamps to the signed range of a w-bit result (w <= 63).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [64:0] sum;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sum   = {a[63], a} + {b[63], b};
        max_v = (65'sd1 <<< (w - 1)) - 65'sd1;
        min_v = -max_v - 65'sd1;
        if (sum > max_v) begin
            return max_v[63:0];
        end else if (sum < min_v) begin
            return min_v[63:0];
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/smvm_ofifo.sv
// rtl/smvm_ofifo.sv - result FIFO with occupancy count; push and pop may coincide even when full
module smvm_ofifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/smvm_stream.sv
// rtl/smvm_stream.sv - streaming sparse-matrix x dense-vector multiplier, one dot product per row
module smvm_stream
    import smvm_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int VEC_DEPTH   = DEF_VEC_DEPTH,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int OFIFO_DEPTH = DEF_OFIFO_DEPTH,
    parameter int SAT         = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  cfg_rows,
    input  logic [IDX_W-1:0]  cfg_cols,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_val,
    input  logic [IDX_W-1:0]  in_col,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [IDX_W-1:0]  out_row,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_col
);

    localparam int VA_W  = (VEC_DEPTH > 1) ? $clog2(VEC_DEPTH) : 1;
    localparam int CNT_W = $clog2(OFIFO_DEPTH + 1);
    localparam int FW    = ACC_W + IDX_W;
    localparam int PW    = 2 * DATA_W;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         rows_q, rows_d, cols_q, cols_d, cnt_q, cnt_d;
    logic                     err_cfg_q, err_cfg_d, err_col_q, err_col_d, done_q, done_d;
    logic                     s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [IDX_W-1:0]         s1_row_q, s1_row_d;
    logic signed [PW-1:0]     prod_q, prod_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_next, acc_wrap;
    logic signed [63:0]       acc_sat;
    logic [63-ACC_W:0]        sat_unused;
    logic signed [DATA_W-1:0] vec_mem [VEC_DEPTH];
    logic signed [DATA_W-1:0] vec_rd;
    logic                     vec_we, fire, col_ok, cfg_ok, fifo_push, fifo_pop;
    logic [CNT_W-1:0]         fifo_count;
    logic [FW-1:0]            fifo_rd;

    assign cfg_ok = (cfg_cols != '0) && (32'(cfg_cols) <= VEC_DEPTH);
    assign col_ok = in_col < cols_q;
    assign vec_rd = vec_mem[in_col[VA_W-1:0]];
    assign fire   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        cnt_d      = cnt_q;
        err_cfg_d  = err_cfg_q;
        err_col_d  = err_col_q;
        done_d     = 1'b0;
        s1_valid_d = 1'b0;
        s1_last_d  = s1_last_q;
        s1_row_d   = s1_row_q;
        prod_d     = prod_q;
        vec_we     = 1'b0;
        in_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        rows_d    = cfg_rows;
                        cols_d    = cfg_cols;
                        cnt_d     = '0;
                        err_cfg_d = 1'b0;
                        err_col_d = 1'b0;
                        if (cfg_rows == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_VEC_IN;
                        end
                    end else begin
                        err_cfg_d = 1'b1;
                    end
                end
            end
            ST_VEC_IN: begin
                in_ready = 1'b1;
                if (fire) begin
                    vec_we = 1'b1;
                    if (cnt_q == cols_q - IDX_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_MAT_IN;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_MAT_IN: begin
                // Two beats can be in flight behind the FIFO, so stop accepting with two slots left.
                in_ready = (fifo_count <= CNT_W'(OFIFO_DEPTH - 3));
                if (fire) begin
                    s1_valid_d = 1'b1;
                    s1_last_d  = in_last;
                    s1_row_d   = cnt_q;
                    prod_d     = col_ok ? PW'($signed(in_val)) * PW'(vec_rd) : '0;
                    if (!col_ok) begin
                        err_col_d = 1'b1;
                    end
                    if (in_last) begin
                        cnt_d = cnt_q + IDX_W'(1);
                        if (cnt_q == rows_q - IDX_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && (fifo_count == '0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_wrap = acc_q + ACC_W'(prod_q);
        acc_sat  = sat_add(64'(acc_q), 64'(prod_q), ACC_W);
        acc_next = (SAT != 0) ? acc_sat[ACC_W-1:0] : acc_wrap;
        acc_d    = acc_q;
        if (s1_valid_q) begin
            acc_d = s1_last_q ? '0 : acc_next;
        end
        fifo_push = s1_valid_q && s1_last_q;
    end

    assign sat_unused = acc_sat[63:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            cnt_q      <= '0;
            err_cfg_q  <= 1'b0;
            err_col_q  <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_row_q   <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            cnt_q      <= cnt_d;
            err_cfg_q  <= err_cfg_d;
            err_col_q  <= err_col_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_row_q   <= s1_row_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (vec_we) begin
            vec_mem[cnt_q[VA_W-1:0]] <= $signed(in_val);
        end
    end

    smvm_ofifo #(
        .W     (FW),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({s1_row_q, acc_next}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign fifo_pop  = out_valid && out_ready;
    assign out_data  = fifo_rd[ACC_W-1:0];
    assign out_row   = fifo_rd[FW-1:ACC_W];
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err_cfg   = err_cfg_q;
    assign err_col   = err_col_q;

endmodule

// File: tb/tb_smvm_stream.sv
// tb/tb_smvm_stream.sv - directed self-checking bench for smvm_stream
module tb_smvm_stream;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_rows, cfg_cols;
    logic        in_valid, in_last, out_ready;
    logic [7:0]  in_val, in_col;
    logic        in_ready, out_valid, busy, done, err_cfg, err_col;
    logic [23:0] out_data;
    logic [7:0]  out_row;

    logic        sat1_out_valid, sat0_out_valid;
    logic [15:0] sat1_out_data, sat0_out_data;
    logic        sat1_unused_ready, sat1_unused_busy, sat1_unused_done, sat1_unused_ecfg, sat1_unused_ecol;
    logic        sat0_unused_ready, sat0_unused_busy, sat0_unused_done, sat0_unused_ecfg, sat0_unused_ecol;
    logic [7:0]  sat1_unused_row, sat0_unused_row;

    int checks   = 0;
    int failures = 0;

    smvm_stream u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_col(in_col), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .busy(busy), .done(done), .err_cfg(err_cfg), .err_col(err_col)
    );

    smvm_stream #(.ACC_W(16), .SAT(1)) u_sat1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .in_valid(in_valid), .in_ready(sat1_unused_ready), .in_val(in_val), .in_col(in_col), .in_last(in_last),
        .out_valid(sat1_out_valid), .out_ready(out_ready), .out_data(sat1_out_data), .out_row(sat1_unused_row),
        .busy(sat1_unused_busy), .done(sat1_unused_done), .err_cfg(sat1_unused_ecfg), .err_col(sat1_unused_ecol)
    );

    smvm_stream #(.ACC_W(16), .SAT(0)) u_sat0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .in_valid(in_valid), .in_ready(sat0_unused_ready), .in_val(in_val), .in_col(in_col), .in_last(in_last),
        .out_valid(sat0_out_valid), .out_ready(out_ready), .out_data(sat0_out_data), .out_row(sat0_unused_row),
        .busy(sat0_unused_busy), .done(sat0_unused_done), .err_cfg(sat0_unused_ecfg), .err_col(sat0_unused_ecol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic start_job(input int rows, input int cols);
        start    = 1'b1;
        cfg_rows = 8'(rows);
        cfg_cols = 8'(cols);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input int v, input int c, input bit l);
        int n = 0;
        in_valid = 1'b1;
        in_val   = 8'(v);
        in_col   = 8'(c);
        in_last  = l;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", in_ready, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int exp_row, input int exp_data);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_row"}, out_row, exp_row);
        check({tag, "_data"}, $signed(out_data), exp_data);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0;
        in_valid = 1'b0; in_val = '0; in_col = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_err_cfg", err_cfg, 0);
        check("rst_err_col", err_col, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic two-row job with latency probe
        start_job(2, 3);
        check("t1_busy", busy, 1);
        send_beat(1, 0, 0); send_beat(2, 0, 0); send_beat(3, 0, 0);
        send_beat(2, 0, 0);
        send_beat(-1, 2, 1);
        check("t1_lat_early", out_valid, 0);
        send_beat(0, 0, 1);
        check("t1_lat", out_valid, 1);
        pop_check("t1_r0", 0, -1);
        pop_check("t1_r1", 1, 0);
        wait_done("t1");

        // backpressure: eight rows against a stalled consumer
        start_job(8, 1);
        send_beat(5, 0, 0);
        for (int k = 0; k < 3; k++) send_beat(k + 1, 0, 1);
        in_valid = 1'b1; in_val = 8'd4; in_col = 8'd0; in_last = 1'b1;
        repeat (4) @(negedge clk);
        check("t2_stall_ready", in_ready, 0);
        check("t2_hold_valid", out_valid, 1);
        check("t2_hold_row", out_row, 0);
        check("t2_hold_data", $signed(out_data), 5);
        fork
            begin
                for (int k = 3; k < 8; k++) send_beat(k + 1, 0, 1);
            end
            begin
                out_ready = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    int n = 0;
                    while (!out_valid && n < 100) begin
                        @(negedge clk);
                        n++;
                    end
                    check("t2_valid", out_valid, 1);
                    check("t2_row", out_row, k);
                    check("t2_data", $signed(out_data), 5 * (k + 1));
                    @(posedge clk);
                    @(negedge clk);
                end
                out_ready = 1'b0;
            end
        join
        wait_done("t2");

        // saturating vs wrapping accumulation
        start_job(1, 1);
        send_beat(127, 0, 0);
        send_beat(127, 0, 0); send_beat(127, 0, 0); send_beat(127, 0, 1);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("t3_wide", $signed(out_data), 48387);
        check("t3_sat_valid", sat1_out_valid, 1);
        check("t3_sat", $signed(sat1_out_data), 32767);
        check("t3_wrap_valid", sat0_out_valid, 1);
        check("t3_wrap", $signed(sat0_out_data), -17149);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        wait_done("t3");

        // out-of-range column and illegal configuration
        start_job(1, 3);
        send_beat(1, 0, 0); send_beat(2, 0, 0); send_beat(3, 0, 0);
        send_beat(4, 5, 0);
        send_beat(2, 1, 1);
        check("t4_err_col", err_col, 1);
        pop_check("t4_r0", 0, 4);
        wait_done("t4");
        check("t4_err_col_sticky", err_col, 1);
        start_job(1, 0);
        check("t4_err_cfg", err_cfg, 1);
        check("t4_cfg_idle", busy, 0);
        check("t4_err_col_kept", err_col, 1);

        // zero-row job and start while busy
        start_job(0, 1);
        check("t5_done", done, 1);
        check("t5_idle", busy, 0);
        check("t5_no_out", out_valid, 0);
        check("t5_err_cfg_clr", err_cfg, 0);
        check("t5_err_col_clr", err_col, 0);
        @(negedge clk);
        check("t5_done_pulse", done, 0);
        start_job(1, 129);
        check("t5_err_cfg_big", err_cfg, 1);
        check("t5_big_idle", busy, 0);
        start_job(1, 2);
        check("t5_err_cfg_clr2", err_cfg, 0);
        send_beat(3, 0, 0);
        start_job(5, 1);
        check("t5_still_busy", busy, 1);
        send_beat(4, 0, 0);
        send_beat(2, 1, 1);
        pop_check("t5_r0", 0, 8);
        wait_done("t5");
        check("t5_no_err_col", err_col, 0);

        // asynchronous reset mid-job
        start_job(4, 2);
        send_beat(1, 0, 0); send_beat(1, 0, 0);
        send_beat(1, 0, 1); send_beat(1, 0, 1);
        repeat (3) @(negedge clk);
        check("t6_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_job(1, 2);
        send_beat(2, 0, 0); send_beat(3, 0, 0);
        send_beat(1, 0, 0); send_beat(1, 1, 1);
        pop_check("t6_r0", 0, 5);
        wait_done("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
